inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/loader_pkg.sv | 21 ++
 rtl/inst_loader_byte_packer.sv | 45 ++++
 rtl/inst_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: definitions shared by the instruction loader.
//   - MEM_DEPTH_DEFAULT / ADDR_W_DEFAULT : default memory geometry
//   - LAST_BYTE_IDX                      : byte index of the top byte of a word
//   - state_t                            : loader FSM state encoding
package loader_pkg;

    localparam int MEM_DEPTH_DEFAULT = 64;
    localparam int ADDR_W_DEFAULT    = 6;

    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: collects four bytes little-endian into one 32-bit word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart at byte 0 (start of a new session)
//   byte_en     : a byte is being transferred this cycle
//   byte_in     : the byte
//   word_full   : this transfer is the 4th byte of the word
//   word        : assembled word including the byte currently on byte_in
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  idx_r;
    logic [23:0] low_r;

    // Byte index and the three lower bytes; the top byte is taken live from byte_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= 2'd0;
            low_r <= 24'd0;
        end else if (clear) begin
            idx_r <= 2'd0;
        end else if (byte_en) begin
            case (idx_r)
                2'd0:    low_r[7:0]   <= byte_in;
                2'd1:    low_r[15:8]  <= byte_in;
                2'd2:    low_r[23:16] <= byte_in;
                default: low_r        <= low_r;
            endcase
            idx_r <= idx_r + 2'd1;
        end
    end

    assign word_full = byte_en && (idx_r == LAST_BYTE_IDX);
    assign word      = {byte_in, low_r};

endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a length-prefixed byte stream into instruction memory
// while holding the core in reset.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle pulse that opens a load session
//   byte_in/byte_valid/byte_ready : byte stream handshake
//   mem_we/mem_addr/mem_wdata     : instruction-memory write port
//   cpu_rst           : core reset, released only after a successful load
//   done / err        : session finished / aborted on an oversize length
module inst_loader
    import loader_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t              state_r;
    state_t              state_s;
    logic [7:0]          word_cnt_r;
    logic [ADDR_W-1:0]   word_idx_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;

    logic                accept_s;
    logic                len_accept_s;
    logic                word_full_s;
    logic [31:0]         word_s;
    logic                word_last_s;
    logic                len_zero_s;
    logic                len_too_big_s;

    assign accept_s      = byte_valid && byte_ready;
    assign len_accept_s  = accept_s && (state_r == LEN);
    assign len_zero_s    = (byte_in == 8'd0);
    assign len_too_big_s = ({24'd0, byte_in} > 32'(MEM_DEPTH));
    assign word_last_s   = ({{(32-ADDR_W){1'b0}}, word_idx_r} == ({24'd0, word_cnt_r} - 32'd1));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (len_accept_s),
        .byte_en   (accept_s && (state_r == DATA)),
        .byte_in   (byte_in),
        .word_full (word_full_s),
        .word      (word_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start only matters in IDLE, DONE and ERR.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = LEN;
                else       state_s = IDLE;
            end
            LEN: begin
                if (accept_s) begin
                    if (len_zero_s)         state_s = DONE;
                    else if (len_too_big_s) state_s = ERR;
                    else                    state_s = DATA;
                end else begin
                    state_s = LEN;
                end
            end
            DATA: begin
                if (word_full_s) state_s = WRITE;
                else             state_s = DATA;
            end
            WRITE: begin
                if (word_last_s) state_s = DONE;
                else             state_s = DATA;
            end
            DONE: begin
                if (start) state_s = LEN;
                else       state_s = DONE;
            end
            ERR: begin
                if (start) state_s = LEN;
                else       state_s = ERR;
            end
            default: state_s = IDLE;
        endcase
    end

    // Word count and word index bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= 8'd0;
            word_idx_r <= {ADDR_W{1'b0}};
        end else if (len_accept_s) begin
            word_cnt_r <= byte_in;
            word_idx_r <= {ADDR_W{1'b0}};
        end else if ((state_r == WRITE) && !word_last_s) begin
            word_idx_r <= word_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Write port: captured on the 4th byte so the strobe lands in the WRITE
    // cycle; address and data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= word_full_s;
            if (word_full_s) begin
                mem_addr_r  <= word_idx_r;
                mem_wdata_r <= word_s;
            end
        end
    end

    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    // Status outputs are pure decodes of the state register.
    assign byte_ready = (state_r == LEN) || (state_r == DATA);
    assign cpu_rst    = (state_r != DONE);
    assign done       = (state_r == DONE);
    assign err        = (state_r == ERR);

endmodule
